rs_issue_select: RTL and testbench

- Issue stage directly downstream of the reservation-station entries.
- Each cycle it picks one busy, operand-ready entry with a round-robin arbiter and latches that entry's IS_PACKET into an issue register toward the functional unit.
- It returns a one-hot clear to the chosen entry so the entry frees itself next cycle.
- The issue register uses a valid/ready handshake with the FU, plus a squash for branch recovery.

---
 rtl/rs_issue_select_pkg.sv | 86 ++++++++
 rtl/rs_issue_select_rr_arbiter.sv | 53 +++++
 rtl/rs_issue_select.sv | 112 +++++++++++
 tb/tb_rs_issue_select.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/rs_issue_select_pkg.sv
// -----------------------------------------------------------------------------
// rs_issue_select_pkg
// Shared machine-wide types and sizes for the issue path:
//   - ROB_LEN / RS_LEN : structure depths shared by the back end
//   - operand-select and ALU-function encodings
//   - is_packet_t      : instruction packet held by an RS entry and issued to an FU
//   - IS_PACKET_NOP    : bubble packet loaded into issue registers on reset
// -----------------------------------------------------------------------------
package rs_issue_select_pkg;

    localparam int ROB_LEN = 32;
    localparam int RS_LEN  = 8;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [4:0]  ZERO_REG = 5'd0;

    typedef enum logic [1:0] {
        OPA_IS_RS1  = 2'h0,
        OPA_IS_NPC  = 2'h1,
        OPA_IS_PC   = 2'h2,
        OPA_IS_ZERO = 2'h3
    } alu_opa_select_t;

    typedef enum logic [3:0] {
        OPB_IS_RS2   = 4'h0,
        OPB_IS_I_IMM = 4'h1,
        OPB_IS_S_IMM = 4'h2,
        OPB_IS_B_IMM = 4'h3,
        OPB_IS_U_IMM = 4'h4,
        OPB_IS_J_IMM = 4'h5
    } alu_opb_select_t;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'h00,
        ALU_SUB  = 5'h01,
        ALU_SLT  = 5'h02,
        ALU_SLTU = 5'h03,
        ALU_AND  = 5'h04,
        ALU_OR   = 5'h05,
        ALU_XOR  = 5'h06,
        ALU_SLL  = 5'h07,
        ALU_SRL  = 5'h08,
        ALU_SRA  = 5'h09
    } alu_func_t;

    typedef struct packed {
        logic [31:0]     npc;
        logic [31:0]     pc;
        logic [31:0]     rs1_value;
        logic [31:0]     rs2_value;
        alu_opa_select_t opa_select;
        alu_opb_select_t opb_select;
        logic [31:0]     inst;
        logic [4:0]      dest_reg_idx;
        alu_func_t       alu_func;
        logic            rd_mem;
        logic            wr_mem;
        logic            cond_branch;
        logic            uncond_branch;
        logic            halt;
        logic            illegal;
        logic            csr_op;
        logic            valid;
    } is_packet_t;

    localparam is_packet_t IS_PACKET_NOP = '{
        npc:           32'h0,
        pc:            32'h0,
        rs1_value:     32'h0,
        rs2_value:     32'h0,
        opa_select:    OPA_IS_RS1,
        opb_select:    OPB_IS_RS2,
        inst:          NOP_INST,
        dest_reg_idx:  ZERO_REG,
        alu_func:      ALU_ADD,
        rd_mem:        1'b0,
        wr_mem:        1'b0,
        cond_branch:   1'b0,
        uncond_branch: 1'b0,
        halt:          1'b0,
        illegal:       1'b0,
        csr_op:        1'b0,
        valid:         1'b0
    };

endpackage

// File: rtl/rs_issue_select_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. Scans req upward starting at ptr,
// wrapping from N-1 to 0, and grants the first set bit.
//   req       in  N       request vector
//   ptr       in  log2 N  index with highest priority this cycle
//   grant     out N       one-hot grant (zero when no request)
//   grant_idx out log2 N  index of the granted bit (0 when no request)
//   any       out 1       at least one request present
// N must be a power of two so the index sum wraps by truncation.
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 8,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             any
);

    logic             found_s;
    logic [PTR_W-1:0] idx_s;

    // Priority scan starting at ptr; the first hit wins.
    always_comb begin
        found_s   = 1'b0;
        grant_idx = '0;
        idx_s     = '0;
        for (int i = 0; i < N; i++) begin
            idx_s = ptr + PTR_W'(i);
            if (!found_s && req[idx_s]) begin
                found_s   = 1'b1;
                grant_idx = idx_s;
            end else begin
                found_s   = found_s;
            end
        end
    end

    // One-hot form of the winning index.
    always_comb begin
        if (found_s) begin
            grant = N'(1) << grant_idx;
        end else begin
            grant = '0;
        end
    end

    assign any = found_s;

endmodule

// File: rtl/rs_issue_select.sv
// -----------------------------------------------------------------------------
// rs_issue_select
// Issue stage behind the reservation-station entries. Each cycle one busy,
// operand-ready entry is picked round-robin, its packet is latched into the
// issue register, and a one-hot clear is returned so the entry frees itself
// on the next edge.
//   clock           in   system clock, rising edge
//   reset           in   asynchronous active-high reset
//   entry_packet_in in   packet held by each RS entry
//   entry_busy      in   entry holds an instruction
//   entry_ready     in   entry operands are available
//   squash          in   branch recovery: drop issue register, no grant
//   fu_ready        in   FU accepts issue_packet this cycle
//   issue_packet    out  registered packet to the FU
//   issue_valid     out  issue_packet qualifier
//   clear_vec       out  combinational one-hot clear to the granted entry
//   stall_cycles    out  cycles with issue_valid=1 and fu_ready=0 (wraps)
// -----------------------------------------------------------------------------
module rs_issue_select
    import rs_issue_select_pkg::*;
#(
    parameter int RS_SIZE = RS_LEN,
    parameter int CNT_W   = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  is_packet_t           entry_packet_in [RS_SIZE],
    input  logic [RS_SIZE-1:0]   entry_busy,
    input  logic [RS_SIZE-1:0]   entry_ready,
    input  logic                 squash,
    input  logic                 fu_ready,
    output is_packet_t           issue_packet,
    output logic                 issue_valid,
    output logic [RS_SIZE-1:0]   clear_vec,
    output logic [CNT_W-1:0]     stall_cycles
);

    localparam int PTR_W = $clog2(RS_SIZE);

    is_packet_t         issue_packet_r;
    logic               issue_valid_r;
    logic [PTR_W-1:0]   rr_ptr_r;
    logic [CNT_W-1:0]   stall_cycles_r;

    logic [RS_SIZE-1:0] cand_s;
    logic [RS_SIZE-1:0] grant_onehot_s;
    logic [PTR_W-1:0]   grant_idx_s;
    logic               any_s;
    logic               can_load_s;
    logic               grant_s;
    logic               stall_s;

    // An idle entry reports ready, so busy must qualify it.
    assign cand_s = entry_busy & entry_ready;

    rr_arbiter #(
        .N     (RS_SIZE),
        .PTR_W (PTR_W)
    ) u_arb (
        .req       (cand_s),
        .ptr       (rr_ptr_r),
        .grant     (grant_onehot_s),
        .grant_idx (grant_idx_s),
        .any       (any_s)
    );

    // Load is allowed when the register is empty or draining this edge.
    assign can_load_s = (!issue_valid_r || fu_ready) && !squash;
    assign grant_s    = can_load_s && any_s;
    assign stall_s    = issue_valid_r && !fu_ready && !squash;

    // Clear goes out combinationally so the entry frees on the same edge
    // that captures its packet; held off while reset is asserted.
    always_comb begin
        if (grant_s && !reset) begin
            clear_vec = grant_onehot_s;
        end else begin
            clear_vec = '0;
        end
    end

    // Issue register, round-robin pointer and stall counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            issue_packet_r <= IS_PACKET_NOP;
            issue_valid_r  <= 1'b0;
            rr_ptr_r       <= '0;
            stall_cycles_r <= '0;
        end else begin
            if (grant_s) begin
                issue_packet_r <= entry_packet_in[grant_idx_s];
                issue_valid_r  <= 1'b1;
                rr_ptr_r       <= grant_idx_s + PTR_W'(1);
            end else if (squash || (fu_ready && issue_valid_r)) begin
                issue_valid_r  <= 1'b0;
            end else begin
                issue_valid_r  <= issue_valid_r;
            end

            if (stall_s) begin
                stall_cycles_r <= stall_cycles_r + CNT_W'(1);
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
        end
    end

    assign issue_packet = issue_packet_r;
    assign issue_valid  = issue_valid_r;
    assign stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_rs_issue_select.sv
module tb_rs_issue_select;
    import rs_issue_select_pkg::*;

    logic        clock;
    logic        reset;
    is_packet_t  entry_packet_in [8];
    logic [7:0]  entry_busy;
    logic [7:0]  entry_ready;
    logic        squash;
    logic        fu_ready;
    is_packet_t  issue_packet;
    logic        issue_valid;
    logic [7:0]  clear_vec;
    logic [31:0] stall_cycles;

    int total;
    int bad;
    logic [31:0] exp_q [$];
    logic [31:0] mon_exp;
    logic [7:0]  clr_snap;

    rs_issue_select #(.RS_SIZE(8), .CNT_W(32)) dut (
        .clock           (clock),
        .reset           (reset),
        .entry_packet_in (entry_packet_in),
        .entry_busy      (entry_busy),
        .entry_ready     (entry_ready),
        .squash          (squash),
        .fu_ready        (fu_ready),
        .issue_packet    (issue_packet),
        .issue_valid     (issue_valid),
        .clear_vec       (clear_vec),
        .stall_cycles    (stall_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Advance one cycle; the RS model frees whatever entry was cleared.
    task automatic tick();
        clr_snap = clear_vec;
        @(posedge clock);
        #1;
        entry_busy = entry_busy & ~clr_snap;
    endtask

    // Scoreboard monitor: every packet that leaves the issue register
    // (transfer to the FU or squash) is matched against the expected stream.
    always @(negedge clock) begin
        if (!reset && issue_valid && (fu_ready || squash)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_issue: got pc=%h, required no packet", issue_packet.pc);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("issue_pc", issue_packet.pc, mon_exp);
                chk("issue_npc", issue_packet.npc, mon_exp + 32'd4);
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 8; i++) begin
            entry_packet_in[i]       = IS_PACKET_NOP;
            entry_packet_in[i].pc    = 32'h18 + 32'(8 * i);
            entry_packet_in[i].npc   = 32'h1C + 32'(8 * i);
            entry_packet_in[i].inst  = 32'h0020_8033;
            entry_packet_in[i].dest_reg_idx = 5'(i + 1);
            entry_packet_in[i].valid = 1'b1;
        end

        // Reset with every entry a candidate.
        reset = 1'b1; squash = 1'b0; fu_ready = 1'b1;
        entry_busy = 8'hFF; entry_ready = 8'hFF;
        tick(); tick(); tick();
        #2;
        chk("rst_clear_vec", 32'(clear_vec), 32'h0);
        chk("rst_issue_valid", 32'(issue_valid), 32'h0);
        chk("rst_stall", stall_cycles, 32'h0);
        chk("rst_pc", issue_packet.pc, 32'h0);
        chk("rst_inst", issue_packet.inst, 32'h0000_0013);

        // Release: rr_ptr=0 -> entry 0.
        tick();
        reset = 1'b0; entry_busy = 8'h01;
        #2;
        chk("grant0_clear", 32'(clear_vec), 32'h01);
        exp_q.push_back(32'h18);
        tick();
        #2;
        chk("grant0_valid", 32'(issue_valid), 32'h1);
        chk("idle_ready_no_grant", 32'(clear_vec), 32'h0);
        tick();
        #2;
        chk("drain_valid", 32'(issue_valid), 32'h0);

        // rr_ptr=1 -> entry 2, leaving rr_ptr=3.
        entry_busy = 8'h04; entry_ready = 8'h04;
        #2;
        chk("grant2_clear", 32'(clear_vec), 32'h04);
        exp_q.push_back(32'h28);
        tick();
        entry_busy = 8'b1001_0100; entry_ready = 8'b1001_0100;
        #2;
        chk("rr_4_clear", 32'(clear_vec), 32'h10);
        exp_q.push_back(32'h38);
        tick();
        #2;
        chk("rr_7_clear", 32'(clear_vec), 32'h80);
        exp_q.push_back(32'h50);
        tick();
        #2;
        chk("rr_wrap_2_clear", 32'(clear_vec), 32'h04);
        exp_q.push_back(32'h28);
        tick();
        #2;
        chk("rr_empty_clear", 32'(clear_vec), 32'h0);
        tick();
        #2;
        chk("rr_drain_valid", 32'(issue_valid), 32'h0);

        // Stall: entry 5 issued, FU blocks for three cycles while entry 6 waits.
        entry_busy = 8'h20; entry_ready = 8'h20;
        #2;
        chk("grant5_clear", 32'(clear_vec), 32'h20);
        exp_q.push_back(32'h40);
        tick();
        fu_ready = 1'b0; entry_busy = 8'h40; entry_ready = 8'h40;
        #2;
        chk("stall_clear0", 32'(clear_vec), 32'h0);
        chk("stall_cnt0", stall_cycles, 32'd0);
        tick();
        #2;
        chk("stall_cnt1", stall_cycles, 32'd1);
        tick();
        #2;
        chk("stall_cnt2", stall_cycles, 32'd2);
        chk("stall_clear2", 32'(clear_vec), 32'h0);
        tick();
        #2;
        chk("stall_cnt3", stall_cycles, 32'd3);
        chk("stall_pc_hold", issue_packet.pc, 32'h40);
        fu_ready = 1'b1;
        #1;
        chk("unstall_grant6", 32'(clear_vec), 32'h40);
        exp_q.push_back(32'h48);

        // Squash with FU stalled and entry 2 ready.
        tick();
        fu_ready = 1'b0; squash = 1'b1;
        entry_busy = 8'h04; entry_ready = 8'h04;
        #2;
        chk("squash_clear", 32'(clear_vec), 32'h0);
        chk("squash_pre_valid", 32'(issue_valid), 32'h1);
        tick();
        #2;
        chk("squash_valid", 32'(issue_valid), 32'h0);
        chk("squash_stall_hold", stall_cycles, 32'd3);

        // rr_ptr=7 -> wraps to entry 2; hold it with the FU stalled.
        squash = 1'b0; fu_ready = 1'b1;
        #2;
        chk("post_squash_grant2", 32'(clear_vec), 32'h04);
        tick();
        fu_ready = 1'b0; entry_busy = 8'hFF; entry_ready = 8'hFF;
        #2;
        chk("pre_rst_valid", 32'(issue_valid), 32'h1);
        chk("pre_rst_pc", issue_packet.pc, 32'h28);

        // Asynchronous reset between edges.
        reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(issue_valid), 32'h0);
        chk("async_rst_pc", issue_packet.pc, 32'h0);
        chk("async_rst_inst", issue_packet.inst, 32'h0000_0013);
        chk("async_rst_pkt_valid", 32'(issue_packet.valid), 32'h0);
        chk("async_rst_clear", 32'(clear_vec), 32'h0);
        chk("async_rst_stall", stall_cycles, 32'h0);
        tick();
        tick();
        chk("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
